// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
//   Shared definitions for the mux_scan_seq channel selector:
//     - state_e    : sequencer state type (IDLE / SCAN) and its 1-bit encoding
//     - DEF_*      : default channel count, data width and dwell time
//     - sel_width(): width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package mux_scan_pkg;

   // Sequencer state. IDLE covers both manual steering and waiting for start.
   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int DEF_N_IN = 6;
   localparam int DEF_W    = 8;
   localparam int DEF_HOLD = 4;

   // Index width for n channels. A single channel still needs one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : mux_scan_pkg

// File: rtl/mux_core.sv
// -----------------------------------------------------------------------------
// mux_core
//   Purely combinational N_IN:1 word selector.
//
//   Parameters
//     N_IN      number of channels
//     W         data width per channel
//   Ports
//     in_bus    in   N_IN*W   packed channels, channel k at in_bus[k*W +: W]
//     sel       in   SW       channel index
//     word      out  W        selected channel, zero when sel is out of range
//     in_range  out  1        sel addresses an existing channel (sel < N_IN)
// -----------------------------------------------------------------------------
module mux_core
   import mux_scan_pkg::*;
#(
   parameter int N_IN = DEF_N_IN,
   parameter int W    = DEF_W
) (
   input  logic [N_IN*W-1:0]            in_bus,
   input  logic [sel_width(N_IN)-1:0]   sel,
   output logic [W-1:0]                 word,
   output logic                         in_range
);

   localparam int SW = sel_width(N_IN);

   // A compare-per-channel structure never indexes past the bus, so an
   // out-of-range select simply matches nothing and reports in_range=0.
   always_comb begin
      // NOTE: every output gets a default before the loop; a path that skips
      // an assignment in combinational logic would otherwise infer a latch.
      word     = '0;
      in_range = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         if (sel == SW'(k)) begin
            word     = in_bus[k*W +: W];
            in_range = 1'b1;
         end
      end
   end

endmodule : mux_core

// File: rtl/mux_scan_seq.sv
// -----------------------------------------------------------------------------
// mux_scan_seq
//   Registered N_IN-way channel selector with an auto-scan sequencer.
//   In manual mode (mode=0) the channel addressed by S is registered every
//   cycle. With mode=1 a start pulse launches a pass that samples channel
//   0..N_IN-1 in turn, dwelling HOLD cycles on each.
//
//   Build option
//     SCAN_WRAP_EN  defined   : scanning wraps to channel 0 and runs until
//                               mode drops or reset
//                   undefined : one pass per start, then back to IDLE
//
//   Parameters
//     N_IN      channel count (2..16)
//     W         data width per channel
//     HOLD      dwell cycles per channel in scan mode (>=1)
//     SW        channel index width (derived, do not override)
//   Ports
//     clk        in   1        system clock, rising edge
//     reset      in   1        asynchronous, active-high reset
//     in_bus     in   N_IN*W   packed channels, channel k at in_bus[k*W +: W]
//     S          in   SW       manual channel select
//     mode       in   1        0 = manual, 1 = auto-scan enable
//     start      in   1        one-cycle request to begin a scan pass
//     out_data   out  W        registered selected data
//     out_ch     out  SW       channel index of out_data
//     out_valid  out  1        out_data/out_ch were updated at the last edge
//     busy       out  1        scan in progress
//     err        out  1        sticky: a manual S >= N_IN was seen
// -----------------------------------------------------------------------------
module mux_scan_seq
   import mux_scan_pkg::*;
#(
   parameter int N_IN = DEF_N_IN,
   parameter int W    = DEF_W,
   parameter int HOLD = DEF_HOLD,
   parameter int SW   = sel_width(N_IN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IN*W-1:0] in_bus,
   input  logic [SW-1:0]     S,
   input  logic              mode,
   input  logic              start,
   output logic [W-1:0]      out_data,
   output logic [SW-1:0]     out_ch,
   output logic              out_valid,
   output logic              busy,
   output logic              err
);

   localparam int            CW       = $clog2(HOLD + 1);
   localparam logic [SW-1:0] CH_LAST  = SW'(N_IN - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

`ifdef SCAN_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // State and next-state
   // ---------------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [SW-1:0]   ch_q,    ch_d;      // channel being dwelt on in SCAN
   logic [CW-1:0]   cnt_q,   cnt_d;     // dwell cycles elapsed on ch_q
   logic [W-1:0]    data_q,  data_d;
   logic [SW-1:0]   och_q,   och_d;
   logic            valid_q, valid_d;
   logic            err_q,   err_d;

   // ---------------------------------------------------------------------------
   // Channel selector: S steers it while idle, the scan counter while scanning
   // ---------------------------------------------------------------------------
   logic [SW-1:0]   core_sel;
   logic [W-1:0]    core_word;
   logic            core_in_range;

   assign core_sel = (state_q == SCAN) ? ch_q : S;

   mux_core #(
      .N_IN (N_IN),
      .W    (W)
   ) u_mux_core (
      .in_bus   (in_bus),
      .sel      (core_sel),
      .word     (core_word),
      .in_range (core_in_range)
   );

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      och_d   = och_q;
      valid_d = 1'b0;      // valid is a pulse: only a fresh sample raises it
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            // Counters are parked at zero so a scan always begins at
            // channel 0 with a full dwell.
            ch_d  = '0;
            cnt_d = '0;
            if (!mode) begin
               if (core_in_range) begin
                  data_d  = core_word;
                  och_d   = S;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start) begin
               state_d = SCAN;
            end
         end

         SCAN: begin
            // start is not looked at here, so a repeated start cannot
            // restart a pass in progress.
            if (!mode) begin
               state_d = IDLE;
               ch_d    = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = core_word;
               och_d   = ch_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               if (ch_q == CH_LAST) begin
                  ch_d = '0;
                  // Single-pass builds leave SCAN on the last sample edge,
                  // so busy falls while that final out_valid is high.
                  if (!WRAP) begin
                     state_d = IDLE;
                  end
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: every register, counters included, is cleared by the asynchronous
   // reset, so no partial pass can survive a reset mid-scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update together from values sampled at the same edge.
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         och_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         och_q   <= och_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = och_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == SCAN);
   assign err       = err_q;

endmodule : mux_scan_seq

// File: tb/tb_mux_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_seq
//   Self-checking bench for mux_scan_seq (N_IN=6, W=8, HOLD=4). Directed
//   scenarios use channel k = 0x10+k; a randomized phase follows. Expected
//   outputs come from a timeline model: a scan started at edge E0 samples
//   channel k at E0+(k+1)*HOLD. Honours SCAN_WRAP_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mux_scan_seq;

   localparam int N_IN = 6;
   localparam int W    = 8;
   localparam int HOLD = 4;
   localparam int SW   = 3;

`ifdef SCAN_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [N_IN*W-1:0] in_bus;
   logic [SW-1:0]     S;
   logic              mode;
   logic              start;
   logic [W-1:0]      out_data;
   logic [SW-1:0]     out_ch;
   logic              out_valid;
   logic              busy;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;

   mux_scan_seq #(
      .N_IN (N_IN),
      .W    (W),
      .HOLD (HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_bus    (in_bus),
      .S         (S),
      .mode      (mode),
      .start     (start),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: scan timeline measured from the start edge
   // ---------------------------------------------------------------------------
   bit          m_scan;
   int          m_e0;
   int          m_edge;
   logic [W-1:0]  m_data;
   logic [SW-1:0] m_ch;
   logic        m_valid;
   logic        m_err;

   task automatic model_reset();
      m_scan  = 1'b0;
      m_e0    = 0;
      m_edge  = 0;
      m_data  = '0;
      m_ch    = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   // Called at each rising edge with the inputs that edge samples.
   task automatic model_edge();
      int d;
      int k;
      m_edge++;
      m_valid = 1'b0;
      if (!m_scan) begin
         if (!mode) begin
            if (int'(S) < N_IN) begin
               m_data  = in_bus[int'(S)*W +: W];
               m_ch    = S;
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end else if (start) begin
            m_scan = 1'b1;
            m_e0   = m_edge;
         end
      end else if (!mode) begin
         m_scan = 1'b0;
      end else begin
         d = m_edge - m_e0;
         if (d % HOLD == 0) begin
            k       = (d / HOLD - 1) % N_IN;
            m_data  = in_bus[k*W +: W];
            m_ch    = SW'(k);
            m_valid = 1'b1;
            if (!WRAP && (d / HOLD == N_IN)) m_scan = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/out_data"},  out_data,  m_data);
      check({tag, "/out_ch"},    out_ch,    m_ch);
      check({tag, "/out_valid"}, out_valid, m_valid);
      check({tag, "/busy"},      busy,      m_scan);
      check({tag, "/err"},       err,       m_err);
   endtask

   // One clock edge: model follows the edge, outputs compared 1 ns later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from any edge.
   task automatic pulse_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      check({tag, "/zero_data"}, out_data, 0);
      #1 reset = 1'b0;
   endtask

   task automatic load_pattern();
      for (int k = 0; k < N_IN; k++) in_bus[k*W +: W] = 8'h10 + 8'(k);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [W-1:0] got_q[$];

   initial begin
      reset = 1'b1;
      mode  = 1'b0;
      start = 1'b0;
      S     = '0;
      load_pattern();
      model_reset();

      // Reset values
      #12;
      check_all("reset");
      #1 reset = 1'b0;

      // Manual, S=3
      S = 3'd3;
      step("man_s3");
      check("man_s3/data_13", out_data, 8'h13);
      check("man_s3/valid",   out_valid, 1);

      // Manual, out of range; err sticks after returning in range
      S = 3'd7;
      step("man_s7");
      check("man_s7/data_hold", out_data, 8'h13);
      check("man_s7/err",       err, 1);
      S = 3'd0;
      step("man_s0");
      check("man_s0/err_sticky", err, 1);
      check("man_s0/data_10",    out_data, 8'h10);
      pulse_reset("rst_a");

      // Idle with mode=1, no start: hold, no valid
      mode = 1'b1;
      step("idle_hold");

      // Single pass (or wrapping scan) from start at E0
      start = 1'b1;
      step("e0");
      start = 1'b0;
      for (int e = 1; e <= 24; e++) begin
         step("scan");
         check("scan/valid_slot", out_valid, (e % HOLD == 0));
         if (e % HOLD == 0) check("scan/ch_data", out_data, 8'h10 + 8'(e / HOLD - 1));
      end
      check("pass_end/busy", busy, WRAP);
      if (WRAP) begin
         for (int e = 25; e <= 28; e++) step("wrap");
         check("wrap/e28_data", out_data, 8'h10);
         check("wrap/e28_ch",   out_ch, 0);
         for (int e = 29; e <= 30; e++) step("wrap");
         pulse_reset("wrap_rst");
      end else begin
         for (int e = 25; e <= 28; e++) step("post_pass");
         check("post_pass/busy", busy, 0);
      end
      mode = 1'b0;
      pulse_reset("rst_b");

      // Abort: mode drops before E10
      mode  = 1'b1;
      start = 1'b1;
      step("ab_e0");
      start = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         if (e == 10) mode = 1'b0;
         step("abort");
      end
      check("abort/busy",  busy, 0);
      check("abort/data",  out_data, 8'h11);
      check("abort/valid", out_valid, 0);
      S = 3'd2;
      step("abort_resume");
      check("abort_resume/data", out_data, 8'h12);
      pulse_reset("rst_c");

      // Second start at E6 is ignored
      mode  = 1'b1;
      start = 1'b1;
      step("ss_e0");
      start = 1'b0;
      got_q.delete();
      for (int e = 1; e <= 24; e++) begin
         start = (e == 6);
         step("restart");
         if (out_valid) got_q.push_back(out_data);
      end
      start = 1'b0;
      check("restart/count", got_q.size(), N_IN);
      for (int k = 0; k < N_IN && k < got_q.size(); k++)
         check("restart/seq", got_q[k], 8'h10 + 8'(k));
      mode = 1'b0;
      pulse_reset("rst_d");

      // Reset mid-scan: no partial pass resumes
      mode  = 1'b1;
      start = 1'b1;
      step("mr_e0");
      start = 1'b0;
      for (int e = 1; e <= 10; e++) step("midrst");
      pulse_reset("midrst_rst");
      for (int e = 0; e < 10; e++) begin
         step("no_resume");
         check("no_resume/busy", busy, 0);
      end
      mode = 1'b0;

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         in_bus = {16'($urandom), $urandom};
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         start = ($urandom_range(0, 7) == 0);
         S = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                          : 3'($urandom_range(0, 5));
         step("rnd");
         if ($urandom_range(0, 249) == 0) pulse_reset("rnd_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mux_scan_seq
